// File: rtl/hpdl1414_scanner_if.sv
// Display-side bundle of the HPDL1414 scanner: buffer read port, caret strobe and the four-chip display bus.
// The scanner uses the master modport; the buffer and display side use the slave modport.
interface hpdl1414_scanner_if;
  logic       i_enable;
  logic       o_read_enable;
  logic [3:0] o_read_address;
  logic [7:0] i_read_data;
  logic       o_caret_strobe;
  logic [6:0] o_data;
  logic [1:0] o_addr;
  logic [3:0] o_wr_n;
  logic       o_frame_done;

  modport master (
    input  i_enable, i_read_data,
    output o_read_enable, o_read_address, o_caret_strobe,
    output o_data, o_addr, o_wr_n, o_frame_done
  );

  modport slave (
    output i_enable, i_read_data,
    input  o_read_enable, o_read_address, o_caret_strobe,
    input  o_data, o_addr, o_wr_n, o_frame_done
  );
endinterface

// File: rtl/hpdl1414_scanner.sv
// Sweeps a 16-byte display buffer into four HPDL1414 chips, one timed WR pulse per character,
// and generates a free-running caret blink square wave.
module hpdl1414_scanner #(
  parameter int SETUP_CYCLES = 2,
  parameter int WR_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int FRAME_GAP    = 1000,
  parameter int BLINK_DIV    = 6000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  hpdl1414_scanner_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  localparam int MAX_A   = (SETUP_CYCLES > WR_CYCLES) ? SETUP_CYCLES : WR_CYCLES;
  localparam int MAX_B   = (HOLD_CYCLES > FRAME_GAP) ? HOLD_CYCLES : FRAME_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CARET_W = $clog2(BLINK_DIV + 1);
  localparam logic [CARET_W-1:0] CARET_LAST = CARET_W'(BLINK_DIV - 1);

  logic [2:0]         state_reg, state_next;
  logic [3:0]         pos_reg, pos_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               frame_done_next;
  logic               read_enable_reg;
  logic [3:0]         read_address_reg;
  logic [6:0]         data_reg;
  logic [1:0]         addr_reg;
  logic [3:0]         wr_n_reg;
  logic               frame_done_reg;
  logic [CARET_W-1:0] caret_cnt_reg;
  logic               caret_reg;

  // Printable ASCII passes, lower case folds to upper case, anything else shows as a blank.
  function automatic logic [6:0] to_glyph(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h5F) return b[6:0];
    if (b >= 8'h61 && b <= 8'h7A) return b[6:0] - 7'h20;
    return 7'h20;
  endfunction

  always_comb begin
    state_next      = state_reg;
    pos_next        = pos_reg;
    cnt_next        = cnt_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        pos_next = 4'd0;
        if (bus.i_enable) state_next = S_READ;
      end
      S_READ:  state_next = S_LATCH;
      S_LATCH: begin
        state_next = S_SETUP;
        cnt_next   = CNT_W'(SETUP_CYCLES - 1);
      end
      S_SETUP: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next = S_STROBE;
          cnt_next   = CNT_W'(WR_CYCLES - 1);
        end
      end
      S_STROBE: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next = S_HOLD;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      S_HOLD: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          frame_done_next = (pos_reg == 4'd15);
          // Enable is only honoured on a character boundary so WR is never cut short.
          if (!bus.i_enable) begin
            state_next = S_IDLE;
            pos_next   = 4'd0;
          end else if (pos_reg == 4'd15) begin
            state_next = S_GAP;
            pos_next   = 4'd0;
            cnt_next   = CNT_W'(FRAME_GAP - 1);
          end else begin
            state_next = S_READ;
            pos_next   = pos_reg + 4'd1;
          end
        end
      end
      S_GAP: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) state_next = bus.i_enable ? S_READ : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the display pins never glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg        <= S_IDLE;
      pos_reg          <= 4'd0;
      cnt_reg          <= '0;
      read_enable_reg  <= 1'b0;
      read_address_reg <= 4'd0;
      data_reg         <= 7'd0;
      addr_reg         <= 2'd0;
      wr_n_reg         <= 4'hF;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pos_reg          <= pos_next;
      cnt_reg          <= cnt_next;
      read_enable_reg  <= (state_next == S_READ);
      read_address_reg <= pos_next;
      wr_n_reg         <= (state_next == S_STROBE) ? ~(4'b0001 << pos_next[3:2]) : 4'hF;
      frame_done_reg   <= frame_done_next;
      if (state_next == S_LATCH) addr_reg <= 2'd3 - pos_next[1:0];
      if (state_reg == S_LATCH) data_reg <= to_glyph(bus.i_read_data);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      caret_cnt_reg <= '0;
      caret_reg     <= 1'b0;
    end else if (caret_cnt_reg == CARET_LAST) begin
      caret_cnt_reg <= '0;
      caret_reg     <= ~caret_reg;
    end else begin
      caret_cnt_reg <= caret_cnt_reg + 1'b1;
    end
  end

  assign bus.o_read_enable  = read_enable_reg;
  assign bus.o_read_address = read_address_reg;
  assign bus.o_data         = data_reg;
  assign bus.o_addr         = addr_reg;
  assign bus.o_wr_n         = wr_n_reg;
  assign bus.o_frame_done   = frame_done_reg;
  assign bus.o_caret_strobe = caret_reg;
endmodule

// File: tb/tb_hpdl1414_scanner.sv
// Randomized scoreboard bench for hpdl1414_scanner: expected reads and WR pulses are queued by the
// stimulus, and a negedge monitor checks every read, WR pulse, frame timing and the caret wave.
module tb_hpdl1414_scanner;
  localparam int SETUP = 2;
  localparam int WRC   = 4;
  localparam int HOLD  = 2;
  localparam int GAP   = 20;
  localparam int BLINK = 3;
  localparam int CHAR  = 2 + SETUP + WRC + HOLD;

  typedef struct {
    logic [1:0] chip;
    logic [1:0] addr;
    logic [6:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hpdl1414_scanner_if bus ();

  hpdl1414_scanner #(
    .SETUP_CYCLES(SETUP), .WR_CYCLES(WRC), .HOLD_CYCLES(HOLD),
    .FRAME_GAP(GAP), .BLINK_DIV(BLINK)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] buf_mem [16];
  wr_t wr_q[$];
  int  rd_q[$];
  bit  gap_check = 1'b0;
  int  k_cnt;

  // Display buffer: one clock of read latency.
  always @(posedge clk)
    if (bus.o_read_enable) bus.i_read_data <= buf_mem[bus.o_read_address];

  always @(posedge clk or posedge rst)
    if (rst) k_cnt <= 0;
    else     k_cnt <= k_cnt + 1;

  function automatic logic [6:0] glyph(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h5F) return b[6:0];
    if (b >= 8'h61 && b <= 8'h7A) return 7'(b - 8'h20);
    return 7'h20;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  task automatic push_frame(input int npos);
    for (int p = 0; p < npos; p++) begin
      wr_q.push_back('{chip: 2'(p / 4), addr: 2'(3 - p % 4), data: glyph(buf_mem[p])});
      rd_q.push_back(p);
    end
  endtask

  task automatic random_buffer();
    for (int p = 0; p < 16; p++) buf_mem[p] = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_frame_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.o_frame_done) begin
        check("frame_done_seen", 1, 1);
        return;
      end
    end
    check("frame_done_timeout", 0, 1);
  endtask

  // Monitor: per-cycle checks plus per-transaction scoreboard comparisons.
  initial begin
    int cyc = 0, last_read = 0, frame_start = 0, fd_cyc = 0;
    bit in_pulse = 0, fd_pending = 0, have_read = 0, p_stable = 0;
    int p_len = 0, lows, low_idx;
    logic [1:0] p_chip, p_addr;
    logic [6:0] p_data;
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      check("caret", int'(bus.o_caret_strobe), (k_cnt / BLINK) % 2);
      if (rst) begin
        in_pulse = 0; fd_pending = 0; have_read = 0;
      end else begin
        lows = 0; low_idx = 0;
        for (int c = 3; c >= 0; c--) if (!bus.o_wr_n[c]) begin lows++; low_idx = c; end
        if (lows > 1) check("wr_n_onehot", lows, 1);
        if (lows >= 1) begin
          if (!in_pulse) begin
            in_pulse = 1; p_len = 1; p_stable = 1;
            p_chip = 2'(low_idx); p_addr = bus.o_addr; p_data = bus.o_data;
            check("read_to_wr_delay", cyc - last_read, 2 + SETUP);
          end else begin
            p_len++;
            if (p_chip != 2'(low_idx) || p_addr != bus.o_addr || p_data != bus.o_data) p_stable = 0;
          end
        end else if (in_pulse) begin
          in_pulse = 0;
          if (wr_q.size() == 0) check("unexpected_wr_pulse", 1, 0);
          else begin
            e = wr_q.pop_front();
            $display("wr chip=%0d addr=%0d data=0x%02h len=%0d", p_chip, p_addr, p_data, p_len);
            check("wr_chip", p_chip, e.chip);
            check("wr_addr", p_addr, e.addr);
            check("wr_data", p_data, e.data);
            check("wr_len", p_len, WRC);
            check("wr_bus_stable", p_stable, 1);
          end
        end
        if (bus.o_read_enable) begin
          if (rd_q.size() == 0) check("unexpected_read", 1, 0);
          else check("read_address", bus.o_read_address, rd_q.pop_front());
          if (bus.o_read_address != 0 && have_read) check("char_period", cyc - last_read, CHAR);
          if (bus.o_read_address == 0) begin
            frame_start = cyc;
            if (fd_pending && gap_check) check("gap_length", cyc - fd_cyc, GAP);
            fd_pending = 0;
          end
          last_read = cyc; have_read = 1;
        end
        if (bus.o_frame_done) begin
          check("frame_done_timing", cyc - frame_start, 16 * CHAR);
          fd_pending = 1; fd_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int reads;
    bus.i_enable = 1'b0;
    for (int p = 0; p < 16; p++) buf_mem[p] = 8'h41 + 8'(p);
    repeat (2) @(negedge clk);
    check("rst_wr_n", bus.o_wr_n, 4'hF);
    check("rst_read_enable", bus.o_read_enable, 0);
    check("rst_data", bus.o_data, 0);
    check("rst_frame_done", bus.o_frame_done, 0);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_wr_n", bus.o_wr_n, 4'hF);

    // Three continuous frames: fixed pattern, conversion corner bytes, random.
    push_frame(16);
    gap_check = 1'b1;
    bus.i_enable = 1'b1;
    wait_frame_done();
    random_buffer();
    buf_mem[0] = 8'h61; buf_mem[1] = 8'h7F; buf_mem[2] = 8'h1F; buf_mem[3] = 8'h5F;
    push_frame(16);
    wait_frame_done();
    random_buffer();
    push_frame(16);
    wait_frame_done();
    bus.i_enable = 1'b0;
    gap_check = 1'b0;
    repeat (GAP + 10) @(negedge clk);

    // Enable dropped during SETUP of position 5.
    random_buffer();
    push_frame(6);
    bus.i_enable = 1'b1;
    begin
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk);
        if (bus.o_read_enable && bus.o_read_address == 4'd5) found = 1;
      end
      check("pos5_read_seen", found, 1);
    end
    repeat (2) @(negedge clk);
    bus.i_enable = 1'b0;
    reads = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_read_enable) reads++;
    end
    check("idle_after_drop_reads", reads, 0);
    check("pos5_wr_completed", wr_q.size(), 0);
    random_buffer();
    push_frame(16);
    bus.i_enable = 1'b1;
    wait_frame_done();
    bus.i_enable = 1'b0;
    repeat (GAP + 10) @(negedge clk);

    // Reset asserted in the middle of a WR pulse.
    random_buffer();
    push_frame(16);
    bus.i_enable = 1'b1;
    begin
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk);
        if (bus.o_wr_n != 4'hF) found = 1;
      end
      check("strobe_seen", found, 1);
    end
    #2 rst = 1'b1;
    #1;
    check("midstrobe_rst_wr_n", bus.o_wr_n, 4'hF);
    check("midstrobe_rst_read_enable", bus.o_read_enable, 0);
    check("midstrobe_rst_read_address", bus.o_read_address, 0);
    check("midstrobe_rst_data", bus.o_data, 0);
    check("midstrobe_rst_addr", bus.o_addr, 0);
    check("midstrobe_rst_frame_done", bus.o_frame_done, 0);
    check("midstrobe_rst_caret", bus.o_caret_strobe, 0);
    wr_q.delete();
    rd_q.delete();
    random_buffer();
    push_frame(16);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("first_read_after_rst", bus.o_read_enable, 1);
    check("first_read_addr_after_rst", bus.o_read_address, 0);
    wait_frame_done();
    bus.i_enable = 1'b0;
    repeat (GAP + 10) @(negedge clk);
    check("wr_queue_drained", wr_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
